branch_target_loader: RTL and testbench
=======================================

Name: branch_target_loader

Overview:
Writer side of the branch-target lookup table. The block accepts a stream of 3-bit branch-target entries over a valid/ready handshake and packs each group of ENTRIES entries into one table row. It then issues a one-cycle write of that row into the target table at the current program index. It loads all PROGRAMS rows per start command, so the table is filled at run time rather than from a preloaded file.

Parameters:
ENTRY_W, 3, width of one branch-target entry
ENTRIES, 8, entries per program row (row width = ENTRY_W*ENTRIES = 24)
PROGRAMS, 3, number of program rows loaded per start
PROG_W, 2, width of program/row index (must satisfy 2**PROG_W >= PROGRAMS)

Ports:
CLK  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
start  in  1  begin a full table load; sampled only in IDLE
abort  in  1  cancel the load from any state; has priority over all other inputs
in_valid  in  1  in_data holds a valid entry
in_data  in  ENTRY_W  branch-target entry
in_ready  out  1  loader accepts an entry this cycle
wr_en  out  1  one-cycle table write strobe
wr_addr  out  PROG_W  row (program index) being written
wr_data  out  ENTRY_W*ENTRIES  packed row
busy  out  1  high in FILL and WRITE
done  out  1  one-cycle pulse when the last row has been written

Behaviour:
- Reset (async, Reset_n=0) forces state=IDLE, row=0, entry count=0, pack register=0. All outputs go to 0: in_ready, wr_en, wr_addr, wr_data, busy, done.
- All state is registered. in_ready, wr_en, busy and done are decoded from state only; none depends combinationally on in_valid.
- States:
  - IDLE: if start, clear row, entry count and pack register, then go to FILL. Otherwise stay.
  - FILL: in_ready=1. A handshake (in_valid & in_ready) places in_data in slot k = entry count and increments the count.
    - Slot k occupies bits [ENTRY_W*(ENTRIES-k)-1 : ENTRY_W*(ENTRIES-k-1)]. Slot 0 is the MSBs, matching read address 0 at [23:21].
    - When the ENTRIES-th handshake occurs, go to WRITE.
    - If in_valid=0, stall: no state change and no timeout.
  - WRITE: in_ready=0, wr_en=1 for exactly one cycle, wr_addr=row, wr_data=pack register.
    - If row==PROGRAMS-1, go to DONE.
    - Otherwise increment row, clear the entry count and go to FILL.
  - DONE: done=1 for one cycle, then go to IDLE.
- wr_addr and wr_data hold their last values outside WRITE. They are meaningful only while wr_en=1.
- abort=1 in any state: return to IDLE next cycle, with no wr_en and no done. A partially packed row is discarded. Rows already written stay written.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins and the state stays IDLE.
- Entries are never dropped. An entry is consumed only on a handshake in FILL.
- Row index saturates logically: no write is ever issued with wr_addr >= PROGRAMS.
- Minimum latency with continuous in_valid, start sampled at cycle 0:
  - FILL entered at cycle 1.
  - Row r written at cycle 9*(r+1).
  - done at cycle 9*PROGRAMS+1, which is cycle 28 for defaults.

Test Plan:
1. Reset_n low mid-FILL (after 5 entries) -> next edge all outputs 0, state IDLE. A following start plus 24 entries loads normally from row 0.
2. start at cycle 0, continuous entries 0,1,...,7 for each row -> wr_en at cycles 9, 18, 27 with wr_addr 0, 1, 2 and wr_data=0x053977 each time; done at cycle 28; busy high for cycles 1-27.
3. Entries 7,6,...,0 for row 0 -> wr_data=0xFAC688 at wr_addr=0.
4. in_valid low for 3 cycles after the 4th entry of row 1 -> in_ready stays high, row 1 write delayed by exactly 3 cycles (cycle 21), data unchanged; done at cycle 31.
5. abort after 6 entries of row 2 -> no third wr_en, no done, IDLE next cycle. A start during FILL is ignored, and a start in DONE does not restart the load.
6. start and abort asserted together in IDLE -> remains IDLE, busy=0, no in_ready.

Source files
------------

// File: rtl/branch_target_loader.sv
// Branch-target table writer: packs ENTRIES entries per row from a valid/ready
// stream and issues one table write per row, PROGRAMS rows per start.
module branch_target_slot #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (ld)   q <= d;
  end
endmodule

module branch_target_loader #(
  parameter int ENTRY_W  = 3,
  parameter int ENTRIES  = 8,
  parameter int PROGRAMS = 3,
  parameter int PROG_W   = 2
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [ENTRY_W-1:0]         in_data,
  output logic                       in_ready,
  output logic                       wr_en,
  output logic [PROG_W-1:0]          wr_addr,
  output logic [ENTRY_W*ENTRIES-1:0] wr_data,
  output logic                       busy,
  output logic                       done
);
  localparam int ROW_W = ENTRY_W * ENTRIES;
  localparam int CNT_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t                           state_q, state_d;
  logic [PROG_W-1:0]                row_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [ENTRIES-1:0][ENTRY_W-1:0]  slot_q;
  logic [ROW_W-1:0]                 row_next;
  logic                             go, take, last_entry, last_row;

  assign go         = (state_q == IDLE) && start && !abort;
  assign take       = (state_q == FILL) && in_valid && !abort;
  assign last_entry = (cnt_q == CNT_W'(ENTRIES - 1));
  assign last_row   = (row_q == PROG_W'(PROGRAMS - 1));

  // Slot k sits at packed index ENTRIES-1-k so slot 0 ends up in the row MSBs.
  for (genvar k = 0; k < ENTRIES; k++) begin : g_slot
    branch_target_slot #(.W(ENTRY_W)) u_slot (
      .CLK     (CLK),
      .Reset_n (Reset_n),
      .clr     (go),
      .ld      (take && (cnt_q == CNT_W'(k))),
      .d       (in_data),
      .q       (slot_q[ENTRIES-1-k])
    );
  end

  // Row as it will look once the entry being accepted now is merged in.
  always_comb begin
    row_next = slot_q;
    row_next[ENTRY_W*(ENTRIES-1-int'(cnt_q)) +: ENTRY_W] = in_data;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    wr_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = FILL;
      FILL: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_entry) state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        busy    = 1'b1;
        state_d = last_row ? DONE : FILL;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      if (go) begin
        row_q <= '0;
        cnt_q <= '0;
      end
      if (take) begin
        if (last_entry) begin
          wr_addr <= row_q;
          wr_data <= row_next;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
      if (state_q == WRITE && !abort) begin
        cnt_q <= '0;
        if (!last_row) row_q <= row_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_target_loader.sv
// Scoreboard bench for branch_target_loader: driver pushes expected writes/done
// from a shift-pack row model; a negedge monitor pops and compares.
module tb_branch_target_loader;
  localparam int EW = 3, NE = 8, NP = 3, PW = 2, RW = EW * NE;

  logic          CLK = 1'b0, Reset_n = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
  logic [EW-1:0] in_data = '0;
  logic          in_ready, wr_en, busy, done;
  logic [PW-1:0] wr_addr;
  logic [RW-1:0] wr_data;

  branch_target_loader #(.ENTRY_W(EW), .ENTRIES(NE), .PROGRAMS(NP), .PROG_W(PW)) dut (
    .CLK(CLK), .Reset_n(Reset_n), .start(start), .abort(abort), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct { bit is_done; int addr; logic [RW-1:0] data; int cyc; } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0, cyc = 0, start_cyc = 0;
  int wrel[NP];
  int done_rel;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (Reset_n && wr_en) begin
      if (q.size() == 0) chk("unexpected_write", 32'(wr_addr), 32'hdead);
      else begin
        e = q.pop_front();
        chk("write_kind", 32'(e.is_done), 32'd0);
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("write_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.is_done && e.addr < NP) wrel[e.addr] = cyc - start_cyc;
      end
    end
    if (Reset_n && done) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("done_kind", 32'(e.is_done), 32'd1);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
        done_rel = cyc - start_cyc;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({nm, "_wr_en"},    32'(wr_en),    32'd0);
    chk({nm, "_wr_addr"},  32'(wr_addr),  32'd0);
    chk({nm, "_wr_data"},  32'(wr_data),  32'd0);
    chk({nm, "_busy"},     32'(busy),     32'd0);
    chk({nm, "_done"},     32'(done),     32'd0);
  endtask

  // stop_kind: 0 none, 1 abort, 2 reset, applied before entry stop_k of row stop_row.
  // patt: 0 ascending, 1 descending, 2 random.
  task automatic do_load(input int stop_row, input int stop_k, input int stop_kind,
                         input int stall_row, input int stall_k, input int stall_n,
                         input int stall_pct, input int patt,
                         input bit start_noise, input bit start_in_done);
    logic [RW-1:0] pk;
    logic [EW-1:0] e;
    exp_t x;
    int n;
    for (int r = 0; r < NP; r++) wrel[r] = -1;
    done_rel  = -1;
    start     = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    for (int r = 0; r < NP; r++) begin
      pk = '0;
      for (int k = 0; k < NE; k++) begin
        n = (r == stall_row && k == stall_k) ? stall_n : 0;
        while (n < 3 && $urandom_range(0, 99) < stall_pct) n++;
        for (int s = 0; s < n; s++) begin
          in_valid = 1'b0;
          chk("stall_in_ready", 32'(in_ready), 32'd1);
          tick();
        end
        case (patt)
          0:       e = EW'(k);
          1:       e = EW'(NE - 1 - k);
          default: e = EW'($urandom_range(0, 7));
        endcase
        if (stop_kind != 0 && r == stop_row && k == stop_k) begin
          if (stop_kind == 1) begin
            abort = 1'b1; in_valid = 1'b1; in_data = e;
            tick();
            abort = 1'b0; in_valid = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_in_ready", 32'(in_ready), 32'd0);
          end else begin
            Reset_n = 1'b0;
            #1;
            chk_all_zero("rst_async");
            tick();
            chk_all_zero("rst_edge");
            Reset_n = 1'b1;
          end
          start = 1'b0;
          return;
        end
        in_valid = 1'b1;
        in_data  = e;
        if (start_noise) start = 1'($urandom_range(0, 1));
        chk("fill_in_ready", 32'(in_ready), 32'd1);
        chk("fill_busy", 32'(busy), 32'd1);
        tick();
        in_valid = 1'b0;
        start    = 1'b0;
        pk = (pk << EW) | RW'(e);
      end
      x.is_done = 1'b0; x.addr = r; x.data = pk; x.cyc = cyc;
      q.push_back(x);
      chk("write_in_ready", 32'(in_ready), 32'd0);
      chk("write_busy", 32'(busy), 32'd1);
      tick();
    end
    x.is_done = 1'b1; x.addr = 0; x.data = '0; x.cyc = cyc;
    q.push_back(x);
    chk("done_busy", 32'(busy), 32'd0);
    chk("hold_wr_addr", 32'(wr_addr), 32'(NP - 1));
    chk("hold_wr_data", 32'(wr_data), 32'(pk));
    start = start_in_done;
    tick();
    start = 1'b0;
    chk("after_done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    Reset_n = 1'b1;
    tick();

    // Ascending entries, no stalls: fixed latency.
    do_load(0, 0, 0, -1, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("t2_row0_cycle", 32'(wrel[0]), 32'd9);
    chk("t2_row1_cycle", 32'(wrel[1]), 32'd18);
    chk("t2_row2_cycle", 32'(wrel[2]), 32'd27);
    chk("t2_done_cycle", 32'(done_rel), 32'd28);
    chk("t2_row_value", 32'(dut.wr_data), 32'h053977);
    tick();

    // Descending entries.
    do_load(0, 0, 0, -1, 0, 0, 0, 1, 1'b0, 1'b0);
    chk("t3_row_value", 32'(wr_data), 32'hFAC688);
    tick();

    // 3-cycle stall after the 4th entry of row 1.
    do_load(0, 0, 0, 1, 4, 3, 0, 0, 1'b0, 1'b0);
    chk("t4_row0_cycle", 32'(wrel[0]), 32'd9);
    chk("t4_row1_cycle", 32'(wrel[1]), 32'd21);
    chk("t4_row2_cycle", 32'(wrel[2]), 32'd30);
    chk("t4_done_cycle", 32'(done_rel), 32'd31);
    tick();

    // Reset mid-FILL after 5 entries, then a normal load from row 0.
    do_load(0, 5, 2, -1, 0, 0, 0, 0, 1'b0, 1'b0);
    chk("t1_queue_empty", 32'(q.size()), 32'd0);
    tick();
    do_load(0, 0, 0, -1, 0, 0, 0, 2, 1'b0, 1'b0);
    chk("t1_reload_row0", 32'(wrel[0]), 32'd9);
    tick();

    // Start noise in FILL and start in DONE, then abort after 6 entries of row 2.
    do_load(0, 0, 0, -1, 0, 0, 0, 2, 1'b1, 1'b1);
    do_load(2, 6, 1, -1, 0, 0, 0, 2, 1'b1, 1'b0);
    repeat (4) begin
      tick();
      chk("t5_idle_busy", 32'(busy), 32'd0);
    end
    chk("t5_no_third_write", 32'(wrel[2]), 32'hFFFFFFFF);
    chk("t5_no_done", 32'(done_rel), 32'hFFFFFFFF);

    // start and abort together in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("t6_busy_later", 32'(busy), 32'd0);

    // Randomized loads with random stalls and occasional aborts.
    for (int i = 0; i < 15; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_load(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, NE - 1)), 1,
                -1, 0, 0, 20, 2, 1'b1, 1'b0);
      else
        do_load(0, 0, 0, -1, 0, 0, 20, 2, 1'b1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (3) tick();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
